// File: rtl/mem_access_unit.sv
// mem_access_unit
// Load/store unit between the CPU datapath and a word-addressed memory.
// Accepts one byte-addressed load or store per request, converts it into
// word-indexed memRead/memWrite cycles, and returns sign- or zero-extended
// load data. Sub-word stores are done as read-modify-write. Misaligned,
// illegal-size and out-of-range requests are answered with resp_err=1 and
// never touch memory.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   req_valid/req_ready request handshake
//   req_write           1 = store, 0 = load
//   req_size            00 byte, 01 half, 10 word, 11 illegal
//   req_signed          loads only: sign-extend sub-word results
//   req_addr            byte address
//   req_wdata           store data, right-aligned
//   resp_valid          one-cycle completion pulse
//   resp_err            request rejected (valid with resp_valid)
//   resp_rdata          last load result, held until the next load completes
//   adress              word index to memory
//   data                write word to memory
//   memRead, memWrite   memory strobes (never both high)
//   memOut              memory read data, valid the cycle after memRead
//   dbg_state           current FSM state (IDLE=0 READ=1 MERGE=2 WRITE=3 DONE=4)
//
// Handshake: a request transfers on a rising edge where req_valid and
// req_ready are both high. req_ready is high only in IDLE, so a transfer is
// followed by a busy window that ends with the single resp_valid cycle;
// req_* inputs are ignored while req_ready is low.

module mem_access_unit #(
  parameter int MEM_WORDS = 200
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic        resp_err,
  output logic [31:0] resp_rdata,
  output logic [31:0] adress,
  output logic [31:0] data,
  output logic        memRead,
  output logic        memWrite,
  input  logic [31:0] memOut,
  output logic [2:0]  dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_MERGE = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [31:0] MEM_LIMIT = 32'(MEM_WORDS);

  state_t      state_q, state_d;

  // Latched request fields
  logic        write_q;
  logic [1:0]  size_q;
  logic        signed_q;
  logic [1:0]  lane_q;
  logic [15:0] wdata_q;
  logic        err_q;

  logic [31:0] rdata_q;
  logic [31:0] adress_q;
  logic [31:0] data_q;

  logic        req_bad;
  logic [31:0] req_index;
  logic        accept;

  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic [31:0] load_val;
  logic [31:0] merge_val;

  assign req_index = {2'b00, req_addr[31:2]};
  assign accept    = (state_q == S_IDLE) && req_valid;

  // Rejection checks on the incoming request.
  always_comb begin
    req_bad = 1'b0;
    if (req_size == 2'b11)                             req_bad = 1'b1;
    if (req_size == 2'b01 && req_addr[0])              req_bad = 1'b1;
    if (req_size == 2'b10 && req_addr[1:0] != 2'b00)   req_bad = 1'b1;
    if (req_index >= MEM_LIMIT)                        req_bad = 1'b1;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          if (req_bad)
            state_d = S_DONE;
          else if (req_write && req_size == 2'b10)
            state_d = S_WRITE;
          else
            state_d = S_READ;
        end
      end
      S_READ:  state_d = S_MERGE;
      S_MERGE: state_d = write_q ? S_WRITE : S_DONE;
      S_WRITE: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Little-endian lane selection from the returned memory word.
  always_comb begin
    lane_b = memOut[7:0];
    case (lane_q)
      2'd0: lane_b = memOut[7:0];
      2'd1: lane_b = memOut[15:8];
      2'd2: lane_b = memOut[23:16];
      2'd3: lane_b = memOut[31:24];
      default: lane_b = memOut[7:0];
    endcase
    lane_h = lane_q[1] ? memOut[31:16] : memOut[15:0];
  end

  // Load result with extension; req_signed only matters for sub-word sizes.
  always_comb begin
    load_val = memOut;
    case (size_q)
      2'b00:   load_val = {{24{signed_q & lane_b[7]}}, lane_b};
      2'b01:   load_val = {{16{signed_q & lane_h[15]}}, lane_h};
      default: load_val = memOut;
    endcase
  end

  // Sub-word store: splice the new bits into the word just read.
  always_comb begin
    merge_val = memOut;
    if (size_q == 2'b00) begin
      case (lane_q)
        2'd0: merge_val[7:0]   = wdata_q[7:0];
        2'd1: merge_val[15:8]  = wdata_q[7:0];
        2'd2: merge_val[23:16] = wdata_q[7:0];
        2'd3: merge_val[31:24] = wdata_q[7:0];
        default: merge_val = memOut;
      endcase
    end else if (size_q == 2'b01) begin
      if (lane_q[1])
        merge_val[31:16] = wdata_q;
      else
        merge_val[15:0]  = wdata_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      write_q  <= 1'b0;
      size_q   <= 2'b00;
      signed_q <= 1'b0;
      lane_q   <= 2'b00;
      wdata_q  <= 16'h0;
      err_q    <= 1'b0;
      rdata_q  <= 32'h0;
      adress_q <= 32'h0;
      data_q   <= 32'h0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        write_q  <= req_write;
        size_q   <= req_size;
        signed_q <= req_signed;
        lane_q   <= req_addr[1:0];
        wdata_q  <= req_wdata[15:0];
        err_q    <= req_bad;
        // adress only moves for requests that will strobe memory, so it
        // holds its previous value across rejected requests.
        if (!req_bad) begin
          adress_q <= req_index;
          if (req_write && req_size == 2'b10)
            data_q <= req_wdata;
        end
      end
      if (state_q == S_MERGE) begin
        if (write_q)
          data_q  <= merge_val;
        else
          rdata_q <= load_val;
      end
    end
  end

  assign req_ready  = (state_q == S_IDLE);
  assign resp_valid = (state_q == S_DONE);
  assign resp_err   = (state_q == S_DONE) && err_q;
  assign resp_rdata = rdata_q;
  assign adress     = adress_q;
  assign data       = data_q;
  assign memRead    = (state_q == S_READ);
  assign memWrite   = (state_q == S_WRITE);
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

  localparam int MW = 200;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_err;
  logic [31:0] resp_rdata;
  logic [31:0] adress;
  logic [31:0] data;
  logic        memRead;
  logic        memWrite;
  logic [31:0] memOut;
  logic [2:0]  dbg_state;

  int total = 0;
  int bad   = 0;

  logic [32:0] exp_q[$];      // {err, rdata}
  logic [31:0] mem    [MW];   // memory attached to the DUT
  logic [31:0] shadow [MW];   // bench's own view of what memory should hold
  logic [31:0] last_rd;

  mem_access_unit #(.MEM_WORDS(MW)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_size(req_size), .req_signed(req_signed),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_err(resp_err), .resp_rdata(resp_rdata),
    .adress(adress), .data(data), .memRead(memRead), .memWrite(memWrite),
    .memOut(memOut), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- memory model ----------------
  always @(posedge clk) begin
    if (memWrite && adress < MW) mem[adress] = data;
    if (memRead) memOut <= (adress < MW) ? mem[adress] : 32'hx;
  end

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h expected=0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference functions ----------------
  function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [1:0] sz,
                                           input logic sg, input logic [1:0] ln);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'(w >> (8 * ln));
    h = ln[1] ? w[31:16] : w[15:0];
    if (sz == 2'b00) return sg ? {{24{b[7]}}, b} : {24'h0, b};
    if (sz == 2'b01) return sg ? {{16{h[15]}}, h} : {16'h0, h};
    return w;
  endfunction

  function automatic logic [31:0] ref_store(input logic [31:0] w, input logic [1:0] sz,
                                            input logic [1:0] ln, input logic [31:0] wd);
    logic [31:0] r;
    r = w;
    if (sz == 2'b00) r[8*ln +: 8] = wd[7:0];
    else if (sz == 2'b01) r[16*ln[1] +: 16] = wd[15:0];
    else r = wd;
    return r;
  endfunction

  function automatic logic ref_err(input logic [1:0] sz, input logic [31:0] a);
    return (sz == 2'b11) || (sz == 2'b01 && a[0]) ||
           (sz == 2'b10 && a[1:0] != 2'b00) || (a[31:2] >= 30'(MW));
  endfunction

  // ---------------- scoreboard: pop on every response ----------------
  always @(negedge clk) begin
    if (!reset && resp_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_resp", 32'd1, 32'd0);
      end else begin
        logic [32:0] e;
        e = exp_q.pop_front();
        chk("resp_err", {31'h0, resp_err}, {31'h0, e[32]});
        chk("resp_rdata", resp_rdata, e[31:0]);
      end
    end
  end

  // ---------------- driver ----------------
  task automatic poke(input int idx, input logic [31:0] v);
    mem[idx]    = v;
    shadow[idx] = v;
  endtask

  // Issue one request; e_rd is the load result expected (ignored otherwise).
  task automatic send(input logic w, input logic [1:0] sz, input logic sg,
                      input logic [31:0] a, input logic [31:0] wd, input logic [31:0] e_rd);
    logic        e_err;
    int          e_lat, e_nr, e_nw, nr, nw, cyc;
    logic [31:0] e_word;
    int          idx;
    e_err = ref_err(sz, a);
    idx   = int'(a[31:2]);
    if (e_err)            begin e_lat = 1; e_nr = 0; e_nw = 0; end
    else if (!w)          begin e_lat = 3; e_nr = 1; e_nw = 0; end
    else if (sz == 2'b10) begin e_lat = 2; e_nr = 0; e_nw = 1; end
    else                  begin e_lat = 4; e_nr = 1; e_nw = 1; end
    e_word = e_err ? 32'h0 : ref_store(shadow[idx], sz, a[1:0], wd);
    if (!e_err && !w) last_rd = e_rd;
    exp_q.push_back({e_err, last_rd});

    @(negedge clk);
    chk("ready_idle", {31'h0, req_ready}, 32'd1);
    req_valid = 1'b1; req_write = w; req_size = sz; req_signed = sg;
    req_addr = a; req_wdata = wd;
    @(negedge clk);
    req_valid = 1'b0;
    req_addr  = $urandom;   // don't-care while busy
    req_wdata = $urandom;
    nr = 0; nw = 0; cyc = 1;
    while (!resp_valid && cyc <= 8) begin
      chk("ready_busy", {31'h0, req_ready}, 32'd0);
      chk("strobe_excl", {31'h0, memRead & memWrite}, 32'd0);
      if (memRead) begin
        nr++;
        chk("rd_adress", adress, {2'b00, a[31:2]});
      end
      if (memWrite) begin
        nw++;
        chk("wr_adress", adress, {2'b00, a[31:2]});
        chk("wr_data", data, e_word);
      end
      @(negedge clk);
      cyc++;
    end
    chk("latency", cyc, e_lat);
    chk("n_read", nr, e_nr);
    chk("n_write", nw, e_nw);
    if (!e_err && w) shadow[idx] = e_word;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] rd_before;
    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
    req_signed = 1'b0; req_addr = 32'h0; req_wdata = 32'h0; memOut = 32'h0;
    last_rd = 32'h0;
    for (int i = 0; i < MW; i++) poke(i, $urandom);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // reset values
    chk("rst_ready", {31'h0, req_ready}, 32'd1);
    chk("rst_state", {29'h0, dbg_state}, 32'd0);
    chk("rst_resp_valid", {31'h0, resp_valid}, 32'd0);
    chk("rst_resp_err", {31'h0, resp_err}, 32'd0);
    chk("rst_rdata", resp_rdata, 32'h0);
    chk("rst_adress", adress, 32'h0);
    chk("rst_data", data, 32'h0);
    chk("rst_memread", {31'h0, memRead}, 32'd0);
    chk("rst_memwrite", {31'h0, memWrite}, 32'd0);

    // word store, then word load back
    send(1'b1, 2'b10, 1'b0, 32'h1A4, 32'hDEADBEEF, 32'h0);
    chk("mem105_word", mem[105], 32'hDEADBEEF);
    send(1'b0, 2'b10, 1'b1, 32'h1A4, 32'h0, 32'hDEADBEEF);

    // sub-word loads
    @(negedge clk); poke(105, 32'h8001FF7F);
    send(1'b0, 2'b00, 1'b1, 32'h1A5, 32'h0, 32'hFFFFFFFF);
    send(1'b0, 2'b00, 1'b0, 32'h1A4, 32'h0, 32'h0000007F);
    send(1'b0, 2'b01, 1'b1, 32'h1A6, 32'h0, 32'hFFFF8001);
    send(1'b0, 2'b01, 1'b0, 32'h1A6, 32'h0, 32'h00008001);

    // sub-word stores
    @(negedge clk); poke(105, 32'h11223344);
    send(1'b1, 2'b00, 1'b0, 32'h1A6, 32'h000000AB, 32'h0);
    chk("mem105_byte", mem[105], 32'h11AB3344);
    send(1'b1, 2'b01, 1'b0, 32'h1A4, 32'h0000CAFE, 32'h0);
    chk("mem105_half", mem[105], 32'h11ABCAFE);

    // errors (resp_rdata must stay at the last load value)
    send(1'b0, 2'b10, 1'b0, 32'h1A6, 32'h0, 32'h0);
    send(1'b0, 2'b01, 1'b0, 32'h1A5, 32'h0, 32'h0);
    send(1'b0, 2'b11, 1'b0, 32'h1A4, 32'h0, 32'h0);
    send(1'b0, 2'b10, 1'b0, 32'd800, 32'h0, 32'h0);
    send(1'b1, 2'b00, 1'b0, 32'd803, 32'h55, 32'h0);
    chk("rdata_after_err", resp_rdata, 32'h00008001);

    // boundary: last valid word
    send(1'b1, 2'b10, 1'b0, 32'd796, 32'h0BADF00D, 32'h0);
    send(1'b0, 2'b00, 1'b1, 32'd799, 32'h0, 32'h0000000B);

    // reset during MERGE of a byte store
    @(negedge clk);
    rd_before = resp_rdata;
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'b00; req_signed = 1'b0;
    req_addr = 32'h1A6; req_wdata = 32'h77;
    @(negedge clk);
    req_valid = 1'b0;
    chk("abort_read", {31'h0, memRead}, 32'd1);
    @(negedge clk);
    chk("abort_merge", {29'h0, dbg_state}, 32'd2);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_nowrite", {31'h0, memWrite}, 32'd0);
    chk("abort_noresp", {31'h0, resp_valid}, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("abort_idle", {29'h0, dbg_state}, 32'd0);
    chk("abort_ready", {31'h0, req_ready}, 32'd1);
    chk("abort_nowrite2", {31'h0, memWrite}, 32'd0);
    chk("abort_mem", mem[105], 32'h11ABCAFE);
    if (rd_before == 32'h0) chk("abort_rdata", resp_rdata, 32'h0);
    last_rd = 32'h0;   // reset clears resp_rdata

    // random mix checked against the shadow model
    for (int n = 0; n < 60; n++) begin
      logic        w, sg;
      logic [1:0]  sz;
      logic [31:0] a, wd, erd;
      w  = 1'($urandom_range(0, 1));
      sg = 1'($urandom_range(0, 1));
      sz = 2'($urandom_range(0, 3));
      a  = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 4 * MW + 16));
      wd = $urandom;
      erd = ref_err(sz, a) ? 32'h0 : ref_load(shadow[a[31:2]], sz, sg, a[1:0]);
      send(w, sz, sg, a, wd, erd);
    end

    repeat (2) @(negedge clk);
    chk("queue_drained", exp_q.size(), 32'd0);
    for (int i = 0; i < MW; i++)
      if (mem[i] !== shadow[i]) chk("mem_final", mem[i], shadow[i]);
    chk("mem_final_105", mem[105], shadow[105]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
